xcfi_rvfi_tracer: RTL and testbench
===================================

Name: xcfi_rvfi_tracer

Overview:
Producer side of the RVFI trace consumed by the per-instruction xcfi_insn_spec checkers.
- Sits beside the core writeback stage and turns each retirement event into exactly one registered RVFI record.
- Maintains the monotonic retirement order and the interrupt/trap flag.
- Pairs load/store retirements with their memory request, which was captured earlier at the memory stage and held in a small queue.

Parameters:
XLEN, 32, architectural data/address width.
ORDER_W, 64, width of rvfi_order counter.
MEMQ_DEPTH, 2, memory-request queue entries (power of two, >=2).

Ports:
g_clk  in  1  clock; all state on rising edge.
g_resetn  in  1  asynchronous active-low reset.
wb_valid  in  1  one instruction retires this cycle.
wb_insn  in  32  retiring instruction encoding.
wb_pc  in  XLEN  retiring PC.
wb_pc_next  in  XLEN  next PC (branch target / trap vector / pc+4).
wb_trap  in  1  retiring instruction trapped.
wb_is_mem  in  1  retiring instruction is a load/store.
wb_rs_addr  in  15  {rs3,rs2,rs1} addresses.
wb_rs_rdata  in  3*XLEN  {rs3,rs2,rs1} read values.
wb_rd_addr  in  5  destination register.
wb_rd_wide  in  1  destination writes a register pair.
wb_rd_wdata  in  2*XLEN  {hi,lo} write data.
wb_mem_rdata  in  XLEN  load data returned for the retiring load.
mem_req_valid  in  1  memory stage issued a request.
mem_req_addr  in  XLEN  request address.
mem_req_rmask  in  4  read byte mask.
mem_req_wmask  in  4  write byte mask.
mem_req_wdata  in  XLEN  store data.
flush  in  1  pipeline flush; cancels queued requests.
rvfi_valid  out  1  record valid (one-cycle pulse per retirement).
rvfi_order  out  ORDER_W  retirement index of this record.
rvfi_insn / rvfi_trap / rvfi_intr  out  32/1/1  instruction, trap flag, first-after-trap flag.
rvfi_pc_rdata / rvfi_pc_wdata  out  XLEN each  current and next PC.
rvfi_rs_addr / rvfi_rs_rdata  out  15 / 3*XLEN  source fields, same packing as wb_rs_*.
rvfi_rd_addr / rvfi_rd_wide / rvfi_rd_wdata  out  5/1/2*XLEN  destination fields.
rvfi_mem_addr / rvfi_mem_rmask / rvfi_mem_wmask  out  XLEN/4/4  memory access fields.
rvfi_mem_wdata / rvfi_mem_rdata  out  XLEN each  memory data fields.
memq_error  out  1  sticky: queue overflow or mem retirement with no request.

Behaviour:
- Reset: async on g_resetn low. All outputs 0, order counter 0, intr_pending 0, queue empty, memq_error 0. Applies mid-operation with no partial record emitted.
- Latency: a record for wb_valid in cycle N is presented with rvfi_valid=1 in cycle N+1 only. rvfi_valid=0 whenever wb_valid was 0; other outputs hold their last values.
- Order:
  - rvfi_order = counter value at capture; counter increments once per wb_valid.
  - Wraps 2^ORDER_W-1 -> 0 silently.
- Destination:
  - If wb_rd_addr==0, both halves of rvfi_rd_wdata are forced to 0 and rvfi_rd_wide to 0.
  - Otherwise, if !wb_rd_wide, the upper half is forced to 0.
- Intr flag:
  - A retirement with wb_trap=1 sets intr_pending.
  - The next retirement is emitted with rvfi_intr=1, and intr_pending clears.
  - If that retirement also traps, intr_pending stays set.
- Memory queue (FIFO, MEMQ_DEPTH):
  - Push {addr,rmask,wmask,wdata} on mem_req_valid.
  - Pop on wb_valid && wb_is_mem.
  - Push+pop with empty queue: bypass; the pushed entry is used and the queue stays empty.
  - Push+pop when full: legal, occupancy unchanged.
  - Push when full, no pop: entry dropped, memq_error set.
  - Pop when empty, no same-cycle push: mem fields 0, memq_error set.
- Memory record fields:
  - Mem record with wb_trap=1: entry popped, but rvfi_mem_rmask/wmask emitted as 0; addr and wdata kept.
  - rvfi_mem_rdata = wb_mem_rdata when rmask!=0 and not trapped, else 0.
  - Non-mem retirement: all rvfi_mem_* = 0, no pop.
- Flush:
  - Empties the queue after any same-cycle pop; a same-cycle push is discarded.
  - A same-cycle retirement is still recorded.
  - Order counter and intr_pending are unaffected.

Decomposition:
- Shared package xcfi_rvfi_pkg holds:
  - the mem-record typedef {addr,rmask,wmask,wdata} and its width constant;
  - RS_PACK_W (15), the rs packing order;
  - RVFI record field-width localparams, so tracer and checker macros agree.
- One sub-module: xcfi_rvfi_memq, a parameterised synchronous FIFO with push/pop/flush, bypass output, full/empty and overflow/underflow strobes.

Test Plan:
- Reset, then three back-to-back non-mem retirements (pc 0x100, 0x104, 0x108) -> rvfi_valid high for cycles N+1..N+3, order 0, 1, 2, mem fields 0.
- Retire with rd=0, wide=1, wdata=0xDEADBEEF_12345678 -> rvfi_rd_wdata=0, rvfi_rd_wide=0. Same with rd=5, wide=0 -> rvfi_rd_wdata=0x00000000_12345678.
- Two loads issued:
  - mem_req addr 0x2000/rmask 0xF, then addr 0x2004/rmask 0x3.
  - Retire both with wb_mem_rdata 0x11, 0x22 -> records in FIFO order (0x2000,0xF,0x11) then (0x2004,0x3,0x22); memq_error stays 0.
  - Third request pushed while full -> memq_error=1.
- Trapping store:
  - Retire with wb_trap=1, wb_pc_next=0x80, wmask 0xF queued -> rvfi_trap=1, wmask 0, pc_wdata 0x80.
  - Next retirement has rvfi_intr=1; the following one rvfi_intr=0.
- Queue one request, assert flush with a simultaneous mem retirement -> retirement consumes the entry; queue empty afterwards. Subsequent mem retire with no request -> mem fields 0, memq_error=1.
- Deassert g_resetn mid-stream with order=7 and one entry queued -> outputs 0 immediately. After release, first record has order 0 and the queue is empty.

Source files
------------

// File: rtl/xcfi_rvfi_pkg.sv
// Shared RVFI definitions: field widths, rs packing and the memory-request record.
// The tracer and the checker macros both use these so their field layouts agree.
package xcfi_rvfi_pkg;

  localparam int unsigned RVFI_XLEN    = 32;
  localparam int unsigned RVFI_ORDER_W = 64;
  localparam int unsigned RVFI_INSN_W  = 32;
  localparam int unsigned RD_ADDR_W    = 5;
  localparam int unsigned MASK_W       = 4;
  // rs addresses packed {rs3,rs2,rs1}, 5 bits each, rs1 in the LSBs
  localparam int unsigned RS_PACK_W    = 15;

  typedef struct packed {
    logic [RVFI_XLEN-1:0] addr;
    logic [MASK_W-1:0]    rmask;
    logic [MASK_W-1:0]    wmask;
    logic [RVFI_XLEN-1:0] wdata;
  } mem_rec_t;

  localparam int unsigned MEM_REC_W = $bits(mem_rec_t);

endpackage

// File: rtl/xcfi_rvfi_tracer_if.sv
// Writeback / memory-stage inputs and RVFI record outputs of the tracer.
// master = core side, slave = tracer.
interface xcfi_rvfi_tracer_if import xcfi_rvfi_pkg::*; #(
  parameter int unsigned XLEN    = RVFI_XLEN,
  parameter int unsigned ORDER_W = RVFI_ORDER_W
);

  logic                   wb_valid;
  logic [RVFI_INSN_W-1:0] wb_insn;
  logic [XLEN-1:0]        wb_pc;
  logic [XLEN-1:0]        wb_pc_next;
  logic                   wb_trap;
  logic                   wb_is_mem;
  logic [RS_PACK_W-1:0]   wb_rs_addr;
  logic [3*XLEN-1:0]      wb_rs_rdata;
  logic [RD_ADDR_W-1:0]   wb_rd_addr;
  logic                   wb_rd_wide;
  logic [2*XLEN-1:0]      wb_rd_wdata;
  logic [XLEN-1:0]        wb_mem_rdata;

  logic                   mem_req_valid;
  logic [XLEN-1:0]        mem_req_addr;
  logic [MASK_W-1:0]      mem_req_rmask;
  logic [MASK_W-1:0]      mem_req_wmask;
  logic [XLEN-1:0]        mem_req_wdata;
  logic                   flush;

  logic                   rvfi_valid;
  logic [ORDER_W-1:0]     rvfi_order;
  logic [RVFI_INSN_W-1:0] rvfi_insn;
  logic                   rvfi_trap;
  logic                   rvfi_intr;
  logic [XLEN-1:0]        rvfi_pc_rdata;
  logic [XLEN-1:0]        rvfi_pc_wdata;
  logic [RS_PACK_W-1:0]   rvfi_rs_addr;
  logic [3*XLEN-1:0]      rvfi_rs_rdata;
  logic [RD_ADDR_W-1:0]   rvfi_rd_addr;
  logic                   rvfi_rd_wide;
  logic [2*XLEN-1:0]      rvfi_rd_wdata;
  logic [XLEN-1:0]        rvfi_mem_addr;
  logic [MASK_W-1:0]      rvfi_mem_rmask;
  logic [MASK_W-1:0]      rvfi_mem_wmask;
  logic [XLEN-1:0]        rvfi_mem_wdata;
  logic [XLEN-1:0]        rvfi_mem_rdata;
  logic                   memq_error;

  modport master (
    output wb_valid, wb_insn, wb_pc, wb_pc_next, wb_trap, wb_is_mem,
           wb_rs_addr, wb_rs_rdata, wb_rd_addr, wb_rd_wide, wb_rd_wdata, wb_mem_rdata,
           mem_req_valid, mem_req_addr, mem_req_rmask, mem_req_wmask, mem_req_wdata, flush,
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs_addr, rvfi_rs_rdata,
           rvfi_rd_addr, rvfi_rd_wide, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_wdata, rvfi_mem_rdata,
           memq_error
  );

  modport slave (
    input  wb_valid, wb_insn, wb_pc, wb_pc_next, wb_trap, wb_is_mem,
           wb_rs_addr, wb_rs_rdata, wb_rd_addr, wb_rd_wide, wb_rd_wdata, wb_mem_rdata,
           mem_req_valid, mem_req_addr, mem_req_rmask, mem_req_wmask, mem_req_wdata, flush,
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs_addr, rvfi_rs_rdata,
           rvfi_rd_addr, rvfi_rd_wide, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_wdata, rvfi_mem_rdata,
           memq_error
  );

endinterface

// File: rtl/xcfi_rvfi_memq.sv
// Small FIFO holding memory requests until their instruction retires.
// pop_data bypasses to push_data when empty; flush clears after any same-cycle pop.
module xcfi_rvfi_memq import xcfi_rvfi_pkg::*; #(
  parameter type         T     = mem_rec_t,
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  input  logic flush,
  output T     pop_data,
  output logic full,
  output logic empty,
  output logic overflow,
  output logic underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign bypass    = push && pop && empty;
  assign do_pop    = pop && !empty;
  // a push into a full queue still fits when the same cycle pops
  assign do_push   = push && !bypass && !flush && (!full || do_pop);
  assign overflow  = push && full && !pop && !flush;
  assign underflow = pop && empty && !push;
  assign pop_data  = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/xcfi_rvfi_tracer.sv
// Turns each writeback retirement into one registered RVFI record, pairing
// load/store retirements with the memory request queued at the memory stage.
module xcfi_rvfi_tracer import xcfi_rvfi_pkg::*; #(
  parameter int unsigned XLEN       = RVFI_XLEN,
  parameter int unsigned ORDER_W    = RVFI_ORDER_W,
  parameter int unsigned MEMQ_DEPTH = 2
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  xcfi_rvfi_tracer_if.slave    bus
);

  mem_rec_t             req;
  mem_rec_t             q_data;
  mem_rec_t             entry;
  logic                 mem_pop;
  logic                 q_over;
  logic                 q_under;
  logic                 q_empty;
  logic                 unused_full;
  logic [ORDER_W-1:0]   order_cnt;
  logic                 intr_pending;

  logic [XLEN-1:0]      maddr_n;
  logic [XLEN-1:0]      mwdata_n;
  logic [XLEN-1:0]      mrdata_n;
  logic [MASK_W-1:0]    rmask_n;
  logic [MASK_W-1:0]    wmask_n;
  logic                 rd_wide_n;
  logic [2*XLEN-1:0]    rd_wdata_n;

  assign req = '{addr:  bus.mem_req_addr,  rmask: bus.mem_req_rmask,
                 wmask: bus.mem_req_wmask, wdata: bus.mem_req_wdata};
  assign mem_pop = bus.wb_valid && bus.wb_is_mem;

  xcfi_rvfi_memq #(
    .T     (mem_rec_t),
    .DEPTH (MEMQ_DEPTH)
  ) u_memq (
    .clk       (g_clk),
    .rst_n     (g_resetn),
    .push      (bus.mem_req_valid),
    .push_data (req),
    .pop       (mem_pop),
    .flush     (bus.flush),
    .pop_data  (q_data),
    .full      (unused_full),
    .empty     (q_empty),
    .overflow  (q_over),
    .underflow (q_under)
  );

  always_comb begin
    entry = '0;
    if (mem_pop && (!q_empty || bus.mem_req_valid)) entry = q_data;
    maddr_n  = entry.addr;
    mwdata_n = entry.wdata;
    // a trapped access never happened: masks cleared, addr/wdata kept for debug
    rmask_n  = bus.wb_trap ? '0 : entry.rmask;
    wmask_n  = bus.wb_trap ? '0 : entry.wmask;
    mrdata_n = (rmask_n != '0) ? bus.wb_mem_rdata : '0;

    rd_wide_n  = 1'b0;
    rd_wdata_n = '0;
    if (bus.wb_rd_addr != '0) begin
      rd_wide_n  = bus.wb_rd_wide;
      rd_wdata_n = bus.wb_rd_wide ? bus.wb_rd_wdata
                                  : {{XLEN{1'b0}}, bus.wb_rd_wdata[XLEN-1:0]};
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      order_cnt          <= '0;
      intr_pending       <= 1'b0;
      bus.rvfi_valid     <= 1'b0;
      bus.rvfi_order     <= '0;
      bus.rvfi_insn      <= '0;
      bus.rvfi_trap      <= 1'b0;
      bus.rvfi_intr      <= 1'b0;
      bus.rvfi_pc_rdata  <= '0;
      bus.rvfi_pc_wdata  <= '0;
      bus.rvfi_rs_addr   <= '0;
      bus.rvfi_rs_rdata  <= '0;
      bus.rvfi_rd_addr   <= '0;
      bus.rvfi_rd_wide   <= 1'b0;
      bus.rvfi_rd_wdata  <= '0;
      bus.rvfi_mem_addr  <= '0;
      bus.rvfi_mem_rmask <= '0;
      bus.rvfi_mem_wmask <= '0;
      bus.rvfi_mem_wdata <= '0;
      bus.rvfi_mem_rdata <= '0;
      bus.memq_error     <= 1'b0;
    end else begin
      bus.rvfi_valid <= bus.wb_valid;
      if (bus.wb_valid) begin
        order_cnt          <= order_cnt + ORDER_W'(1);
        intr_pending       <= bus.wb_trap;
        bus.rvfi_order     <= order_cnt;
        bus.rvfi_insn      <= bus.wb_insn;
        bus.rvfi_trap      <= bus.wb_trap;
        bus.rvfi_intr      <= intr_pending;
        bus.rvfi_pc_rdata  <= bus.wb_pc;
        bus.rvfi_pc_wdata  <= bus.wb_pc_next;
        bus.rvfi_rs_addr   <= bus.wb_rs_addr;
        bus.rvfi_rs_rdata  <= bus.wb_rs_rdata;
        bus.rvfi_rd_addr   <= bus.wb_rd_addr;
        bus.rvfi_rd_wide   <= rd_wide_n;
        bus.rvfi_rd_wdata  <= rd_wdata_n;
        bus.rvfi_mem_addr  <= maddr_n;
        bus.rvfi_mem_rmask <= rmask_n;
        bus.rvfi_mem_wmask <= wmask_n;
        bus.rvfi_mem_wdata <= mwdata_n;
        bus.rvfi_mem_rdata <= mrdata_n;
      end
      if (q_over || q_under) bus.memq_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xcfi_rvfi_tracer.sv
// Scoreboard bench for xcfi_rvfi_tracer: each driven retirement pushes its
// expected record, which is popped and compared one cycle later.
module tb_xcfi_rvfi_tracer;

  typedef struct packed {
    logic        ret, trap, is_mem, wide, req, flush;
    logic [31:0] insn, pc, pc_next;
    logic [4:0]  rd;
    logic [63:0] rd_wdata;
    logic [31:0] mrdata, raddr;
    logic [3:0]  rmask, wmask;
    logic [31:0] rwdata;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, intr;
    logic [31:0] pc_r, pc_w;
    logic [14:0] rs_addr;
    logic [95:0] rs_rdata;
    logic [4:0]  rd_addr;
    logic        rd_wide;
    logic [63:0] rd_wdata;
    logic [31:0] maddr;
    logic [3:0]  rmask, wmask;
    logic [31:0] mwdata, mrdata;
  } rec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask, wmask;
    logic [31:0] wdata;
  } mreq_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks;
  int   errors;

  rec_t        sb[$];
  mreq_t       mq[$];
  logic [63:0] m_order;
  logic        m_intr;
  logic        m_err;

  always #5 clk = ~clk;

  xcfi_rvfi_tracer_if #(.XLEN(32), .ORDER_W(64)) bus ();

  xcfi_rvfi_tracer #(.XLEN(32), .ORDER_W(64), .MEMQ_DEPTH(2)) dut (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .bus      (bus)
  );

  function automatic stim_t s_idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t s_ret(input logic [31:0] pc, input logic mem,
                                  input logic trap, input logic [31:0] mrdata);
    stim_t s = '0;
    s.ret      = 1'b1;
    s.pc       = pc;
    s.pc_next  = pc + 32'd4;
    s.insn     = 32'h0000_0013 | {pc[19:0], 12'h0};
    s.is_mem   = mem;
    s.trap     = trap;
    s.mrdata   = mrdata;
    s.rd       = pc[6:2] | 5'd1;
    s.rd_wdata = {32'hA5A5_0000 ^ pc, pc ^ 32'h1111_1111};
    return s;
  endfunction

  function automatic stim_t s_req(input stim_t base, input logic [31:0] addr,
                                  input logic [3:0] rmask, input logic [3:0] wmask,
                                  input logic [31:0] wdata);
    stim_t s = base;
    s.req    = 1'b1;
    s.raddr  = addr;
    s.rmask  = rmask;
    s.wmask  = wmask;
    s.rwdata = wdata;
    return s;
  endfunction

  function automatic void model_clear();
    sb.delete();
    mq.delete();
    m_order = '0;
    m_intr  = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.valid    = bus.rvfi_valid;
    r.order    = bus.rvfi_order;
    r.insn     = bus.rvfi_insn;
    r.trap     = bus.rvfi_trap;
    r.intr     = bus.rvfi_intr;
    r.pc_r     = bus.rvfi_pc_rdata;
    r.pc_w     = bus.rvfi_pc_wdata;
    r.rs_addr  = bus.rvfi_rs_addr;
    r.rs_rdata = bus.rvfi_rs_rdata;
    r.rd_addr  = bus.rvfi_rd_addr;
    r.rd_wide  = bus.rvfi_rd_wide;
    r.rd_wdata = bus.rvfi_rd_wdata;
    r.maddr    = bus.rvfi_mem_addr;
    r.rmask    = bus.rvfi_mem_rmask;
    r.wmask    = bus.rvfi_mem_wmask;
    r.mwdata   = bus.rvfi_mem_wdata;
    r.mrdata   = bus.rvfi_mem_rdata;
    return r;
  endfunction

  task automatic apply(input stim_t s);
    bus.wb_valid      = s.ret;
    bus.wb_insn       = s.insn;
    bus.wb_pc         = s.pc;
    bus.wb_pc_next    = s.pc_next;
    bus.wb_trap       = s.trap;
    bus.wb_is_mem     = s.is_mem;
    bus.wb_rs_addr    = s.pc[14:0] ^ 15'h1234;
    bus.wb_rs_rdata   = {s.pc + 32'd3, s.pc + 32'd2, s.pc + 32'd1};
    bus.wb_rd_addr    = s.rd;
    bus.wb_rd_wide    = s.wide;
    bus.wb_rd_wdata   = s.rd_wdata;
    bus.wb_mem_rdata  = s.mrdata;
    bus.mem_req_valid = s.req;
    bus.mem_req_addr  = s.raddr;
    bus.mem_req_rmask = s.rmask;
    bus.mem_req_wmask = s.wmask;
    bus.mem_req_wdata = s.rwdata;
    bus.flush         = s.flush;
  endtask

  // Drives one cycle of stimulus and updates the reference model / scoreboard.
  task automatic drive(input stim_t s);
    rec_t  r;
    mreq_t e;
    logic  used;
    @(negedge clk);
    apply(s);
    used = 1'b0;
    if (s.ret) begin
      r          = '0;
      r.valid    = 1'b1;
      r.order    = m_order;
      m_order    = m_order + 64'd1;
      r.insn     = s.insn;
      r.trap     = s.trap;
      r.intr     = m_intr;
      m_intr     = s.trap;
      r.pc_r     = s.pc;
      r.pc_w     = s.pc_next;
      r.rs_addr  = s.pc[14:0] ^ 15'h1234;
      r.rs_rdata = {s.pc + 32'd3, s.pc + 32'd2, s.pc + 32'd1};
      r.rd_addr  = s.rd;
      if (s.rd != 5'd0) begin
        r.rd_wide  = s.wide;
        r.rd_wdata = s.wide ? s.rd_wdata : {32'h0, s.rd_wdata[31:0]};
      end
      if (s.is_mem) begin
        e = '0;
        if (mq.size() > 0) e = mq.pop_front();
        else if (s.req) begin
          e.addr = s.raddr; e.rmask = s.rmask; e.wmask = s.wmask; e.wdata = s.rwdata;
          used = 1'b1;
        end else m_err = 1'b1;
        r.maddr  = e.addr;
        r.mwdata = e.wdata;
        if (!s.trap) begin
          r.rmask = e.rmask;
          r.wmask = e.wmask;
          if (e.rmask != 4'h0) r.mrdata = s.mrdata;
        end
      end
      sb.push_back(r);
    end
    if (s.req && !used && !s.flush) begin
      if (mq.size() < 2) begin
        e.addr = s.raddr; e.rmask = s.rmask; e.wmask = s.wmask; e.wdata = s.rwdata;
        mq.push_back(e);
      end else m_err = 1'b1;
    end
    if (s.flush) mq.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    apply(s_idle());
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rec_t got;
    rst_n = 1'b0;
    apply(s_req(s_ret(32'h100, 1'b0, 1'b0, 32'h0), 32'h10, 4'hF, 4'h0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", got);
    end
    checks++;
    if (bus.memq_error !== 1'b0) begin
      errors++; $display("FAIL reset_memq_error got %b exp 0", bus.memq_error);
    end
    @(negedge clk);
    apply(s_idle());
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    rec_t  got, exp;
    q.push_back(s_ret(32'h100, 1'b0, 1'b0, 32'h0));
    q.push_back(s_ret(32'h104, 1'b0, 1'b0, 32'h0));
    q.push_back(s_ret(32'h108, 1'b0, 1'b0, 32'h0));
    q.push_back(s_idle());
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL b2b[%0d] record got %h exp %h", i, got, exp);
      end
      checks++;
      if (bus.memq_error !== m_err) begin
        errors++; $display("FAIL b2b[%0d] memq_error got %b exp %b", i, bus.memq_error, m_err);
      end
      if (i < 3) begin
        checks++;
        if (got.order !== 64'(i) || got.valid !== 1'b1) begin
          errors++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, got.order, i);
        end
      end
    end
  endtask

  task automatic test_rd_forcing();
    stim_t q[$];
    stim_t s;
    rec_t  got, exp;
    s = s_ret(32'h200, 1'b0, 1'b0, 32'h0);
    s.rd = 5'd0; s.wide = 1'b1; s.rd_wdata = 64'hDEADBEEF_12345678;
    q.push_back(s);
    s = s_ret(32'h204, 1'b0, 1'b0, 32'h0);
    s.rd = 5'd5; s.wide = 1'b0; s.rd_wdata = 64'hDEADBEEF_12345678;
    q.push_back(s);
    s = s_ret(32'h208, 1'b0, 1'b0, 32'h0);
    s.rd = 5'd6; s.wide = 1'b1; s.rd_wdata = 64'hDEADBEEF_12345678;
    q.push_back(s);
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL rd[%0d] record got %h exp %h", i, got, exp);
      end
      if (i == 0) begin
        checks++;
        if (got.rd_wdata !== 64'h0 || got.rd_wide !== 1'b0) begin
          errors++; $display("FAIL rd_zero wdata got %h wide %b exp 0 0", got.rd_wdata, got.rd_wide);
        end
      end else if (i == 1) begin
        checks++;
        if (got.rd_wdata !== 64'h00000000_12345678) begin
          errors++; $display("FAIL rd_narrow wdata got %h exp 0000000012345678", got.rd_wdata);
        end
      end
    end
  endtask

  task automatic test_trap_intr();
    stim_t q[$];
    stim_t s;
    rec_t  got, exp;
    q.push_back(s_req(s_idle(), 32'h4000, 4'h0, 4'hF, 32'hCAFE_F00D));
    s = s_ret(32'h300, 1'b1, 1'b1, 32'h0);
    s.pc_next = 32'h80;
    q.push_back(s);
    q.push_back(s_ret(32'h80, 1'b0, 1'b0, 32'h0));
    q.push_back(s_ret(32'h84, 1'b0, 1'b0, 32'h0));
    q.push_back(s_ret(32'h88, 1'b0, 1'b1, 32'h0));
    q.push_back(s_ret(32'h80, 1'b0, 1'b1, 32'h0));
    q.push_back(s_ret(32'h80, 1'b0, 1'b0, 32'h0));
    q.push_back(s_ret(32'h84, 1'b0, 1'b0, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL trap[%0d] record got %h exp %h", i, got, exp);
      end
      if (i == 1) begin
        checks++;
        if (got.trap !== 1'b1 || got.wmask !== 4'h0 || got.pc_w !== 32'h80 ||
            got.maddr !== 32'h4000 || got.mwdata !== 32'hCAFE_F00D) begin
          errors++; $display("FAIL trap_store got trap %b wmask %h pc_w %h addr %h wdata %h exp 1 0 80 4000 cafef00d",
                             got.trap, got.wmask, got.pc_w, got.maddr, got.mwdata);
        end
      end else if (i >= 2) begin
        checks++;
        if (got.intr !== ((i == 2 || i == 5 || i == 6) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL intr[%0d] got %b", i, got.intr);
        end
      end
    end
  endtask

  task automatic test_flush();
    stim_t q[$];
    stim_t s;
    rec_t  got, exp;
    q.push_back(s_req(s_idle(), 32'h5000, 4'hF, 4'h0, 32'h0));
    s = s_ret(32'h600, 1'b1, 1'b0, 32'h55);
    s.flush = 1'b1;
    q.push_back(s);
    q.push_back(s_ret(32'h604, 1'b1, 1'b0, 32'h66));
    s = s_req(s_idle(), 32'h6000, 4'hF, 4'h0, 32'h0);
    s.flush = 1'b1;
    q.push_back(s);
    q.push_back(s_ret(32'h608, 1'b1, 1'b0, 32'h77));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL flush[%0d] record got %h exp %h", i, got, exp);
      end
      checks++;
      if (bus.memq_error !== m_err) begin
        errors++; $display("FAIL flush[%0d] memq_error got %b exp %b", i, bus.memq_error, m_err);
      end
      if (i == 1) begin
        checks++;
        if (got.maddr !== 32'h5000 || got.mrdata !== 32'h55) begin
          errors++; $display("FAIL flush_pop addr %h rdata %h exp 5000 55", got.maddr, got.mrdata);
        end
      end else if (i == 2) begin
        checks++;
        if (got.maddr !== 32'h0 || got.rmask !== 4'h0 || bus.memq_error !== 1'b1) begin
          errors++; $display("FAIL flush_empty addr %h rmask %h err %b exp 0 0 1", got.maddr, got.rmask, bus.memq_error);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    stim_t q[$];
    rec_t  got, exp;
    apply_reset();
    for (int k = 0; k < 7; k++) q.push_back(s_ret(32'h300 + 32'(4 * k), 1'b0, 1'b0, 32'h0));
    q.push_back(s_req(s_idle(), 32'h7000, 4'hF, 4'h0, 32'h0));
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL midrst[%0d] record got %h exp %h", i, got, exp);
      end
    end
    // retirement in flight when reset hits must not produce a record
    @(negedge clk);
    apply(s_ret(32'h400, 1'b1, 1'b0, 32'h99));
    #2 rst_n = 1'b0;
    #1;
    got = observe();
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL midrst_outputs got %h exp 0", got);
    end
    model_clear();
    @(posedge clk); #1;
    checks++;
    if (bus.rvfi_valid !== 1'b0 || bus.memq_error !== 1'b0) begin
      errors++; $display("FAIL midrst_hold valid %b err %b exp 0 0", bus.rvfi_valid, bus.memq_error);
    end
    @(negedge clk);
    apply(s_idle());
    rst_n = 1'b1;
    drive(s_ret(32'h500, 1'b1, 1'b0, 32'h77));
    @(posedge clk); #1;
    got = observe();
    exp = '0;
    if (sb.size() != 0) exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL midrst_first record got %h exp %h", got, exp);
    end
    checks++;
    if (got.order !== 64'd0 || got.maddr !== 32'h0 || bus.memq_error !== 1'b1) begin
      errors++; $display("FAIL midrst_first order %0d addr %h err %b exp 0 0 1", got.order, got.maddr, bus.memq_error);
    end
  endtask

  task automatic test_loads();
    stim_t q[$];
    rec_t  got, exp;
    apply_reset();
    q.push_back(s_req(s_idle(), 32'h2000, 4'hF, 4'h0, 32'h0));
    q.push_back(s_req(s_idle(), 32'h2004, 4'h3, 4'h0, 32'h0));
    q.push_back(s_ret(32'h700, 1'b1, 1'b0, 32'h11));
    q.push_back(s_ret(32'h704, 1'b1, 1'b0, 32'h22));
    q.push_back(s_req(s_idle(), 32'h3000, 4'hF, 4'h0, 32'h0));
    q.push_back(s_req(s_idle(), 32'h3004, 4'h0, 4'hC, 32'h1234_5678));
    q.push_back(s_req(s_ret(32'h708, 1'b1, 1'b0, 32'h33), 32'h3008, 4'h1, 4'h0, 32'h0));
    q.push_back(s_req(s_idle(), 32'h300C, 4'hF, 4'h0, 32'h0));
    q.push_back(s_ret(32'h70C, 1'b1, 1'b0, 32'h44));
    q.push_back(s_ret(32'h710, 1'b1, 1'b0, 32'h55));
    q.push_back(s_idle());
    foreach (q[i]) begin
      drive(q[i]);
      @(posedge clk); #1;
      got = observe();
      exp = '0;
      if (sb.size() != 0) exp = sb.pop_front();
      checks++;
      if (exp.valid ? (got !== exp) : (got.valid !== 1'b0)) begin
        errors++; $display("FAIL loads[%0d] record got %h exp %h", i, got, exp);
      end
      checks++;
      if (bus.memq_error !== m_err) begin
        errors++; $display("FAIL loads[%0d] memq_error got %b exp %b", i, bus.memq_error, m_err);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (got.maddr !== ((i == 2) ? 32'h2000 : 32'h2004) ||
            got.rmask !== ((i == 2) ? 4'hF : 4'h3) ||
            got.mrdata !== ((i == 2) ? 32'h11 : 32'h22)) begin
          errors++; $display("FAIL load_fifo[%0d] addr %h rmask %h rdata %h", i, got.maddr, got.rmask, got.mrdata);
        end
      end else if (i == 7) begin
        checks++;
        if (bus.memq_error !== 1'b1) begin
          errors++; $display("FAIL overflow memq_error got %b exp 1", bus.memq_error);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply(s_idle());
    model_clear();
    test_reset();
    test_back_to_back();
    test_rd_forcing();
    test_trap_intr();
    test_flush();
    test_reset_midstream();
    test_loads();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
